// File: rtl/req_ack_tracker.sv
// Run-time checker for "rising req is followed ##[1:MAX_WAIT] by ack": pass/fail pulses, latency, counts.
// Optional max-latency statistic built only when REQ_ACK_TRACKER_LATSTAT_EN is defined.
module req_ack_tracker #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16,
    localparam int LW      = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             req,
    input  logic             ack,
    output logic             pending,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             pass,
    output logic [LW-1:0]    latency,
    output logic             fail,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [LW-1:0]    max_lat
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [LW-1:0] AGE_MAX = LW'(MAX_WAIT);

    state_t           state, state_n;
    logic             req_q;
    logic             rose;
    logic [LW-1:0]    age, age_n;
    logic [CNT_W-1:0] pend_n, pass_cnt_n, fail_cnt_n;
    logic             pass_n, fail_n;
    logic [LW-1:0]    latency_n;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign rose    = req & ~req_q;
    assign pending = (state == WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            age      <= '0;
            pend_cnt <= '0;
            pass     <= 1'b0;
            latency  <= '0;
            fail     <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            state    <= state_n;
            req_q    <= req;
            age      <= age_n;
            pend_cnt <= pend_n;
            pass     <= pass_n;
            latency  <= latency_n;
            fail     <= fail_n;
            pass_cnt <= pass_cnt_n;
            fail_cnt <= fail_cnt_n;
        end
    end

    // Only the oldest attempt is aged; younger ones are satisfied or failed with it.
    always_comb begin
        state_n    = state;
        age_n      = age;
        pend_n     = pend_cnt;
        pass_n     = 1'b0;
        fail_n     = 1'b0;
        latency_n  = latency;
        pass_cnt_n = pass_cnt;
        fail_cnt_n = fail_cnt;
        case (state)
            IDLE: begin
                if (rose) begin
                    state_n = WAIT;
                    age_n   = LW'(1);
                    pend_n  = CNT_W'(1);
                end
            end
            WAIT: begin
                if (ack) begin
                    pass_n     = 1'b1;
                    latency_n  = age;
                    pass_cnt_n = sat_add(pass_cnt, pend_cnt);
                    if (rose) begin
                        age_n  = LW'(1);
                        pend_n = CNT_W'(1);
                    end else begin
                        state_n = IDLE;
                        age_n   = '0;
                        pend_n  = '0;
                    end
                end else if (age == AGE_MAX) begin
                    fail_n     = 1'b1;
                    fail_cnt_n = sat_add(fail_cnt, pend_cnt);
                    if (rose) begin
                        age_n  = LW'(1);
                        pend_n = CNT_W'(1);
                    end else begin
                        state_n = IDLE;
                        age_n   = '0;
                        pend_n  = '0;
                    end
                end else begin
                    age_n = age + 1'b1;
                    if (rose && (pend_cnt != {CNT_W{1'b1}}))
                        pend_n = pend_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (clr) begin
            state_n    = IDLE;
            age_n      = '0;
            pend_n     = '0;
            pass_n     = 1'b0;
            fail_n     = 1'b0;
            latency_n  = '0;
            pass_cnt_n = '0;
            fail_cnt_n = '0;
        end
    end

`ifdef REQ_ACK_TRACKER_LATSTAT_EN
    logic [LW-1:0] max_lat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            max_lat_q <= '0;
        else if (clr)
            max_lat_q <= '0;
        else if (pass_n && (latency_n > max_lat_q))
            max_lat_q <= latency_n;
    end

    assign max_lat = max_lat_q;
`else
    assign max_lat = '0;
`endif

endmodule

// File: tb/tb_req_ack_tracker.sv
// Directed bench for req_ack_tracker (MAX_WAIT=6, CNT_W=4): per-cycle vector table plus reset and saturation sequences.
module tb_req_ack_tracker;

    localparam int MAX_WAIT = 6;
    localparam int CNT_W    = 4;
    localparam int LW       = $clog2(MAX_WAIT + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             req;
    logic             ack;
    logic             pending;
    logic [CNT_W-1:0] pend_cnt;
    logic             pass;
    logic [LW-1:0]    latency;
    logic             fail;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [LW-1:0]    max_lat;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int r, a, c;
        int pend, pc, ps, lat, fl, psc, flc, ml;
    } vec_t;

    vec_t vecs[$];

    req_ack_tracker #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .req      (req),
        .ack      (ack),
        .pending  (pending),
        .pend_cnt (pend_cnt),
        .pass     (pass),
        .latency  (latency),
        .fail     (fail),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .max_lat  (max_lat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input int r, a, c, pend, pc, ps, lat, fl, psc, flc, ml);
        vec_t v;
        v = '{r: r, a: a, c: c, pend: pend, pc: pc, ps: ps, lat: lat,
              fl: fl, psc: psc, flc: flc, ml: ml};
        vecs.push_back(v);
    endtask

    task automatic checkField(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Expected max_lat is only non-zero when the statistic is compiled in.
    function automatic int expMaxLat(input int ml);
`ifdef REQ_ACK_TRACKER_LATSTAT_EN
        return ml;
`else
        return 0 * ml;
`endif
    endfunction

    task automatic checkOutput(input string name, input int pend, pc, ps, lat, fl, psc, flc, ml);
        checkField({name, ".pending"},  int'(pending),  pend);
        checkField({name, ".pend_cnt"}, int'(pend_cnt), pc);
        checkField({name, ".pass"},     int'(pass),     ps);
        checkField({name, ".latency"},  int'(latency),  lat);
        checkField({name, ".fail"},     int'(fail),     fl);
        checkField({name, ".pass_cnt"}, int'(pass_cnt), psc);
        checkField({name, ".fail_cnt"}, int'(fail_cnt), flc);
        checkField({name, ".max_lat"},  int'(max_lat),  expMaxLat(ml));
    endtask

    task automatic applyStimulus(input int r, a, c);
        req = 1'(r);
        ack = 1'(a);
        clr = 1'(c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        ack   = 1'b0;
        clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        //      r a c  pend pc ps lat fl psc flc ml
        addVec(0,0,0, 0,0,0,0,0,0,0,0);
        addVec(1,0,0, 1,1,0,0,0,0,0,0);
        addVec(0,0,0, 1,1,0,0,0,0,0,0);
        addVec(0,1,0, 0,0,1,2,0,1,0,2);
        addVec(0,0,0, 0,0,0,2,0,1,0,2);
        addVec(1,0,0, 1,1,0,2,0,1,0,2);
        addVec(1,1,0, 0,0,1,1,0,2,0,2);
        addVec(0,0,0, 0,0,0,1,0,2,0,2);
        // rise with ack in IDLE, then timeout
        addVec(1,1,0, 1,1,0,1,0,2,0,2);
        for (int k = 0; k < 5; k++) addVec(0,0,0, 1,1,0,1,0,2,0,2);
        addVec(0,0,0, 0,0,0,1,1,2,1,2);
        addVec(0,0,0, 0,0,0,1,0,2,1,2);
        // three rises, one ack
        addVec(1,0,0, 1,1,0,1,0,2,1,2);
        addVec(0,0,0, 1,1,0,1,0,2,1,2);
        addVec(1,0,0, 1,2,0,1,0,2,1,2);
        addVec(0,0,0, 1,2,0,1,0,2,1,2);
        addVec(1,0,0, 1,3,0,1,0,2,1,2);
        addVec(0,1,0, 0,0,1,5,0,5,1,5);
        addVec(0,0,0, 0,0,0,5,0,5,1,5);
        // ack and new rise at the same edge
        addVec(1,0,0, 1,1,0,5,0,5,1,5);
        addVec(0,0,0, 1,1,0,5,0,5,1,5);
        addVec(1,1,0, 1,1,1,2,0,6,1,5);
        addVec(0,1,0, 0,0,1,1,0,7,1,5);
        addVec(0,0,0, 0,0,0,1,0,7,1,5);
        // ack exactly at MAX_WAIT passes
        addVec(1,0,0, 1,1,0,1,0,7,1,5);
        for (int k = 0; k < 5; k++) addVec(0,0,0, 1,1,0,1,0,7,1,5);
        addVec(0,1,0, 0,0,1,6,0,8,1,6);
        addVec(0,0,0, 0,0,0,6,0,8,1,6);
        // timeout coinciding with a new rise
        addVec(1,0,0, 1,1,0,6,0,8,1,6);
        for (int k = 0; k < 5; k++) addVec(0,0,0, 1,1,0,6,0,8,1,6);
        addVec(1,0,0, 1,1,0,6,1,8,2,6);
        addVec(0,1,0, 0,0,1,1,0,9,2,6);
        addVec(0,0,0, 0,0,0,1,0,9,2,6);
        // clr mid-WAIT with two outstanding
        addVec(1,0,0, 1,1,0,1,0,9,2,6);
        addVec(0,0,0, 1,1,0,1,0,9,2,6);
        addVec(1,0,0, 1,2,0,1,0,9,2,6);
        addVec(0,0,1, 0,0,0,0,0,0,0,0);
        addVec(0,1,0, 0,0,0,0,0,0,0,0);
        addVec(1,0,0, 1,1,0,0,0,0,0,0);
        addVec(0,1,0, 0,0,1,1,0,1,0,1);
        addVec(0,0,0, 0,0,0,1,0,1,0,1);
        // clr while req held high: req_q still loads, so no new rise afterwards
        addVec(1,0,0, 1,1,0,1,0,1,0,1);
        addVec(1,0,1, 0,0,0,0,0,0,0,0);
        addVec(1,1,0, 0,0,0,0,0,0,0,0);
        addVec(0,0,0, 0,0,0,0,0,0,0,0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].a, vecs[i].c);
            checkOutput($sformatf("vec%0d", i), vecs[i].pend, vecs[i].pc, vecs[i].ps,
                        vecs[i].lat, vecs[i].fl, vecs[i].psc, vecs[i].flc, vecs[i].ml);
        end

        // Asynchronous reset mid-WAIT with two outstanding attempts.
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("prerst", 1, 2, 0, 0, 0, 0, 0, 0);
        req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncrst", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1, 0);
        checkOutput("postrst_ack", 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("postrst_rise", 1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0);
        checkOutput("postrst_pass", 0, 0, 1, 1, 0, 1, 0, 1);

        // pass_cnt saturates at 15 rather than wrapping.
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1, 0, 0);
            applyStimulus(0, 1, 0);
        end
        checkOutput("sat_pass", 0, 0, 1, 1, 0, 15, 0, 1);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 0);
        checkOutput("sat_hold", 0, 0, 1, 3, 0, 15, 0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
